// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle for the multi-cycle MIPS controller.
// master: the controller (drives datapath controls, reads IR fields and memory ready).
// slave : the datapath / memory side.
interface multicycle_control_unit_if #(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6,
   parameter int ALUC_W  = 4,
   parameter int CNT_W   = 32
);
   logic [OP_W-1:0]    op_in;
   logic [FUNCT_W-1:0] func_in;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic [1:0]         pc_source;
   logic               iord;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUC_W-1:0]  alu_cntrl;
   logic               instr_done;
   logic [CNT_W-1:0]   instr_retired;
   logic               trap;

   modport master (
      input  op_in, func_in, mem_ready,
      output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_cntrl, instr_done, instr_retired, trap
   );

   modport slave (
      output op_in, func_in, mem_ready,
      input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_cntrl, instr_done, instr_retired, trap
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing over a
// shared memory and ALU, stalling on mem_ready and counting retired instructions.
// Moore controls are registered (computed from the next state); ir_write, the FETCH
// part of pc_write and the MEMWR/DECODE completion pulses are Mealy terms.
// Optional feature macro: ILLEGAL_TRAP_EN -- illegal op/funct parks the FSM in TRAP
// with trap=1 until reset; without it, illegal encodings retire as a NOP.
module multicycle_control_unit #(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6,
   parameter int ALUC_W  = 4,
   parameter int CNT_W   = 32
) (
   input logic                        clk,
   input logic                        rst_n,
   multicycle_control_unit_if.master  bus
);
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC   = 4'd3,
      S_RWB    = 4'd4,  S_MEMADR = 4'd5,  S_MEMRD  = 4'd6,  S_MEMWB  = 4'd7,
      S_MEMWR  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_BRANCH = 4'd11,
      S_JUMP   = 4'd12, S_TRAP   = 4'd13
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu;
      logic       done;
      logic       trap;
   } ctrl_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

   localparam logic [FUNCT_W-1:0] FN_NOP = FUNCT_W'(6'b000000);
   localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
   localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
   localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
   localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
   localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

   // Moore control word for a given state; EXEC takes its ALU op from the decoded funct.
   function automatic ctrl_t ctrl_of(input state_t st, input logic [3:0] alu_op);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu = ALU_ADD; end
         S_DECODE: begin c.alu_src_b = 2'b11; c.alu = ALU_ADD; end
         S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu = alu_op; end
         S_RWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
         S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu = ALU_ADD; end
         S_MEMRD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
         S_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
         S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
         S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu = ALU_ADD; end
         S_ADDIWB: begin c.reg_write = 1'b1; c.done = 1'b1; end
         S_BRANCH: begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu = ALU_SUB;
            c.pc_write_cond = 1'b1; c.pc_source = 2'b01; c.done = 1'b1;
         end
         S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.done = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP:   begin c.trap = 1'b1; end
`endif
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_t           r_state;
   ctrl_t            r_ctrl;
   logic [3:0]       r_alu_op;
   logic             r_is_lw;
   logic [CNT_W-1:0] r_retired;

   state_t     w_dec_state;
   logic [3:0] w_dec_alu;
   logic       w_dec_lw;
   logic       w_dec_nop;
   state_t     w_next_state;
   logic [3:0] w_next_alu;
   logic       w_in_fetch;
   logic       w_done;

   // Instruction decode of the IR fields; only consumed while in DECODE.
   always_comb begin
      w_dec_state = S_FETCH;
      w_dec_alu   = ALU_ADD;
      w_dec_lw    = 1'b0;
      w_dec_nop   = 1'b0;
      case (bus.op_in)
         OP_RTYPE: begin
            case (bus.func_in)
               FN_ADD:  begin w_dec_state = S_EXEC; w_dec_alu = ALU_ADD; end
               FN_SUB:  begin w_dec_state = S_EXEC; w_dec_alu = ALU_SUB; end
               FN_AND:  begin w_dec_state = S_EXEC; w_dec_alu = ALU_AND; end
               FN_OR:   begin w_dec_state = S_EXEC; w_dec_alu = ALU_OR;  end
               FN_SLT:  begin w_dec_state = S_EXEC; w_dec_alu = ALU_SLT; end
               FN_NOP:  begin w_dec_state = S_FETCH; w_dec_nop = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
               default: begin w_dec_state = S_TRAP; end
`else
               default: begin w_dec_state = S_FETCH; w_dec_nop = 1'b1; end
`endif
            endcase
         end
         OP_LW:   begin w_dec_state = S_MEMADR; w_dec_lw = 1'b1; end
         OP_SW:   begin w_dec_state = S_MEMADR; end
         OP_ADDI: begin w_dec_state = S_ADDIEX; end
         OP_BEQ:  begin w_dec_state = S_BRANCH; end
         OP_J:    begin w_dec_state = S_JUMP; end
`ifdef ILLEGAL_TRAP_EN
         default: begin w_dec_state = S_TRAP; end
`else
         default: begin w_dec_state = S_FETCH; w_dec_nop = 1'b1; end
`endif
      endcase
   end

   // Next-state sequencing, including memory-ready stalls.
   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_IDLE:   w_next_state = S_FETCH;
         S_FETCH:  w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: w_next_state = w_dec_state;
         S_EXEC:   w_next_state = S_RWB;
         S_MEMADR: w_next_state = r_is_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  w_next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_ADDIEX: w_next_state = S_ADDIWB;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP:   w_next_state = S_TRAP;
`endif
         default:  w_next_state = S_FETCH;
      endcase
   end

   assign w_next_alu = (r_state == S_DECODE) ? w_dec_alu : r_alu_op;

   // State register, registered Moore controls and the decoded instruction class.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_ctrl   <= '0;
         r_alu_op <= ALU_ADD;
         r_is_lw  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_ctrl  <= ctrl_of(w_next_state, w_next_alu);
         if (r_state == S_DECODE) begin
            r_alu_op <= w_dec_alu;
            r_is_lw  <= w_dec_lw;
         end
      end
   end

   assign w_in_fetch = (r_state == S_FETCH);
   assign w_done     = r_ctrl.done
                     | ((r_state == S_MEMWR)  & bus.mem_ready)
                     | ((r_state == S_DECODE) & w_dec_nop);

   // Retired-instruction counter; wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
      end else if (w_done) begin
         r_retired <= r_retired + CNT_W'(1'b1);
      end
   end

   assign bus.pc_write      = r_ctrl.pc_write | (w_in_fetch & bus.mem_ready);
   assign bus.ir_write      = w_in_fetch & bus.mem_ready;
   assign bus.pc_write_cond = r_ctrl.pc_write_cond;
   assign bus.pc_source     = r_ctrl.pc_source;
   assign bus.iord          = r_ctrl.iord;
   assign bus.mem_read      = r_ctrl.mem_read;
   assign bus.mem_write     = r_ctrl.mem_write;
   assign bus.reg_dst       = r_ctrl.reg_dst;
   assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
   assign bus.reg_write     = r_ctrl.reg_write;
   assign bus.alu_src_a     = r_ctrl.alu_src_a;
   assign bus.alu_src_b     = r_ctrl.alu_src_b;
   assign bus.alu_cntrl     = ALUC_W'(r_ctrl.alu);
   assign bus.instr_done    = w_done;
   assign bus.instr_retired = r_retired;
   assign bus.trap          = r_ctrl.trap;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (CNT_W=4 so counter wrap is reachable).
module tb_multicycle_control_unit;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   multicycle_control_unit_if #(.OP_W(6), .FUNCT_W(6), .ALUC_W(4), .CNT_W(CNT_W)) bus ();

   multicycle_control_unit #(.OP_W(6), .FUNCT_W(6), .ALUC_W(4), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Output word layout: [19] pc_write [18] pc_write_cond [17:16] pc_source [15] iord
   // [14] mem_read [13] mem_write [12] ir_write [11] reg_dst [10] mem_to_reg [9] reg_write
   // [8] alu_src_a [7:6] alu_src_b [5:2] alu_cntrl [1] instr_done [0] trap
   localparam logic [19:0] B_PCW  = 20'h80000;
   localparam logic [19:0] B_PCWC = 20'h40000;
   localparam logic [19:0] PCS01  = 20'h10000;
   localparam logic [19:0] PCS10  = 20'h20000;
   localparam logic [19:0] B_IORD = 20'h08000;
   localparam logic [19:0] B_MR   = 20'h04000;
   localparam logic [19:0] B_MW   = 20'h02000;
   localparam logic [19:0] B_IRW  = 20'h01000;
   localparam logic [19:0] B_RD   = 20'h00800;
   localparam logic [19:0] B_M2R  = 20'h00400;
   localparam logic [19:0] B_RW   = 20'h00200;
   localparam logic [19:0] B_SA   = 20'h00100;
   localparam logic [19:0] SB01   = 20'h00040;
   localparam logic [19:0] SB10   = 20'h00080;
   localparam logic [19:0] SB11   = 20'h000C0;
   localparam logic [19:0] A_ADD  = 20'h00000;
   localparam logic [19:0] A_SUB  = 20'h00004;
   localparam logic [19:0] A_AND  = 20'h00008;
   localparam logic [19:0] A_SLT  = 20'h00010;
   localparam logic [19:0] A_OR   = 20'h00014;
   localparam logic [19:0] B_DONE = 20'h00002;
   localparam logic [19:0] B_TRAP = 20'h00001;

   localparam logic [19:0] W_F1  = B_PCW | B_MR | B_IRW | SB01;
   localparam logic [19:0] W_F0  = B_MR | SB01;
   localparam logic [19:0] W_D   = SB11;
   localparam logic [19:0] W_DN  = SB11 | B_DONE;
   localparam logic [19:0] W_RWB = B_RD | B_RW | B_DONE;
   localparam logic [19:0] W_MA  = B_SA | SB10;
   localparam logic [19:0] W_MRD = B_IORD | B_MR;
   localparam logic [19:0] W_MWB = B_M2R | B_RW | B_DONE;
   localparam logic [19:0] W_MW0 = B_IORD | B_MW;
   localparam logic [19:0] W_MW1 = B_IORD | B_MW | B_DONE;
   localparam logic [19:0] W_BR  = B_SA | A_SUB | B_PCWC | PCS01 | B_DONE;
   localparam logic [19:0] W_J   = B_PCW | PCS10 | B_DONE;
   localparam logic [19:0] W_AEX = B_SA | SB10;
   localparam logic [19:0] W_AWB = B_RW | B_DONE;

   localparam logic [5:0] X6 = 6'h3F;   // garbage IR value outside DECODE

   int         n_chk;
   int         n_pass;
   logic [3:0] exp_cnt;
   logic [19:0] w_obs;

   assign w_obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord, bus.mem_read,
                   bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                   bus.alu_src_a, bus.alu_src_b, bus.alu_cntrl, bus.instr_done, bus.trap};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // One clock: apply inputs just after the edge, check outputs and count mid-cycle.
   task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input logic [19:0] exp);
      @(posedge clk);
      #1;
      bus.mem_ready = rdy;
      bus.op_in     = op;
      bus.func_in   = fn;
      #1;
      chk({tag, " ctl"}, 32'(w_obs), 32'(exp));
      chk({tag, " cnt"}, 32'(bus.instr_retired), 32'(exp_cnt));
      if (exp[1]) exp_cnt = exp_cnt + 4'd1;
   endtask

   task automatic run_r(input string tag, input logic [5:0] fn, input logic [19:0] alu);
      cyc({tag, " fetch"}, 1'b1, X6, X6, W_F1);
      cyc({tag, " decode"}, 1'b1, 6'h00, fn, W_D);
      cyc({tag, " exec"}, 1'b1, X6, X6, B_SA | alu);
      cyc({tag, " rwb"}, 1'b1, X6, X6, W_RWB);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      exp_cnt = 4'd0;
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      bus.op_in = 6'h00;
      bus.func_in = 6'h00;

      repeat (2) @(posedge clk);
      #2;
      chk("reset ctl", 32'(w_obs), 32'd0);
      chk("reset cnt", 32'(bus.instr_retired), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("idle ctl", 32'(w_obs), 32'd0);

      cyc("fetch stall1", 1'b0, X6, X6, W_F0);
      cyc("fetch stall2", 1'b0, X6, X6, W_F0);
      run_r("add", 6'b100000, A_ADD);
      run_r("sub", 6'b100010, A_SUB);
      run_r("and", 6'b100100, A_AND);
      run_r("or",  6'b100101, A_OR);
      run_r("slt", 6'b101010, A_SLT);

      cyc("lw fetch", 1'b1, X6, X6, W_F1);
      cyc("lw decode", 1'b1, 6'b100011, 6'h15, W_D);
      cyc("lw memadr", 1'b0, X6, X6, W_MA);
      for (int i = 0; i < 3; i++) cyc("lw memrd stall", 1'b0, X6, X6, W_MRD);
      cyc("lw memrd ready", 1'b1, X6, X6, W_MRD);
      cyc("lw memwb", 1'b0, X6, X6, W_MWB);

      cyc("sw fetch", 1'b1, X6, X6, W_F1);
      cyc("sw decode", 1'b1, 6'b101011, 6'h00, W_D);
      cyc("sw memadr", 1'b0, X6, X6, W_MA);
      cyc("sw memwr stall", 1'b0, X6, X6, W_MW0);
      cyc("sw memwr ready", 1'b1, X6, X6, W_MW1);

      cyc("beq fetch", 1'b1, X6, X6, W_F1);
      cyc("beq decode", 1'b1, 6'b000100, 6'h00, W_D);
      cyc("beq branch", 1'b1, X6, X6, W_BR);

      cyc("j fetch", 1'b1, X6, X6, W_F1);
      cyc("j decode", 1'b1, 6'b000010, 6'h00, W_D);
      cyc("j jump", 1'b1, X6, X6, W_J);

      cyc("addi fetch", 1'b1, X6, X6, W_F1);
      cyc("addi decode", 1'b1, 6'b001000, 6'h00, W_D);
      cyc("addi exec", 1'b1, X6, X6, W_AEX);
      cyc("addi wb", 1'b1, X6, X6, W_AWB);

      // Reset asserted in the middle of a memory-read stall.
      cyc("rst lw fetch", 1'b1, X6, X6, W_F1);
      cyc("rst lw decode", 1'b1, 6'b100011, 6'h00, W_D);
      cyc("rst lw memadr", 1'b0, X6, X6, W_MA);
      cyc("rst lw memrd", 1'b0, X6, X6, W_MRD);
      #1 rst_n = 1'b0;
      exp_cnt = 4'd0;
      #1;
      chk("midrst ctl", 32'(w_obs), 32'd0);
      chk("midrst cnt", 32'(bus.instr_retired), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("post-rst idle", 32'(w_obs), 32'd0);
      cyc("post-rst fetch", 1'b0, X6, X6, W_F0);

      // 17 NOPs on a 4-bit counter wrap back to 1.
      for (int i = 0; i < 17; i++) begin
         cyc("nop fetch", 1'b1, X6, X6, W_F1);
         cyc("nop decode", 1'b1, 6'h00, 6'h00, W_DN);
      end
      cyc("wrap fetch", 1'b1, X6, X6, W_F1);
      chk("wrap count", 32'(bus.instr_retired), 32'd1);

      // Illegal opcode 111111.
`ifdef ILLEGAL_TRAP_EN
      cyc("illegal decode", 1'b1, 6'b111111, 6'h00, W_D);
      for (int i = 0; i < 10; i++) cyc("trap hold", 1'b1, X6, X6, B_TRAP);
`else
      cyc("illegal decode", 1'b1, 6'b111111, 6'h00, W_DN);
      cyc("illegal next fetch", 1'b0, X6, X6, W_F0);
      chk("illegal count", 32'(bus.instr_retired), 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
